// File: rtl/scara_pkg.sv
// Shared types and helpers for the SCARA motion sequencer.
package scara_pkg;

    typedef enum logic [1:0] {
        OP_MOVE_ABS = 2'd0,
        OP_MOVE_REL = 2'd1,
        OP_DWELL    = 2'd2,
        OP_PEN      = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_DWELL
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/scara_chunker.sv
// Per-axis chunk slicer: clamps the remaining distance to one step chunk
// and reports its magnitude, direction and signed contribution.
module scara_chunker
    import scara_pkg::*;
#(
    parameter int POS_W    = 14,
    parameter int STEP_W   = 8,
    parameter int STEP_MAX = 255
) (
    input  logic signed [POS_W:0]  remaining,
    output logic [STEP_W-1:0]      count,
    output logic                   dir,
    output logic signed [POS_W:0]  chunk
);

    localparam logic [POS_W:0] MAX_EXT = (POS_W+1)'(STEP_MAX);

    logic [POS_W:0]        magnitude;
    logic signed [POS_W:0] count_ext;

    always_comb begin
        magnitude = remaining[POS_W] ? $unsigned(-remaining) : $unsigned(remaining);
        count     = (magnitude > MAX_EXT) ? MAX_EXT[STEP_W-1:0] : magnitude[STEP_W-1:0];
        dir       = !remaining[POS_W] && (remaining != '0);
        count_ext = $signed({{(POS_W+1-STEP_W){1'b0}}, count});
        chunk     = remaining[POS_W] ? -count_ext : count_ext;
    end

endmodule

// File: rtl/scara_motion_sequencer.sv
// Command sequencer for an N-axis SCARA arm: tracks joint positions and slices
// moves into bounded per-axis step chunks, plus dwell and pen commands.
module scara_motion_sequencer
    import scara_pkg::*;
#(
    parameter int                      N_AXES         = 2,
    parameter int                      POS_W          = 14,
    parameter int                      STEP_W         = 8,
    parameter int                      STEP_MAX       = 255,
    parameter logic signed [POS_W-1:0] HOME_POS       = '0,
    parameter int                      ARG_W          = 16,
    parameter int                      DWELL_PRESCALE = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [N_AXES*POS_W-1:0]    cmd_target,
    input  logic [ARG_W-1:0]           cmd_arg,
    input  logic                       abort,
    output logic                       step_valid,
    input  logic                       step_ready,
    output logic [N_AXES*STEP_W-1:0]   step_count,
    output logic [N_AXES-1:0]          step_dir,
    output logic [N_AXES*POS_W-1:0]    pos_current,
    output logic                       pen_state,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int             PRE_W    = (DWELL_PRESCALE > 1) ? clog2(DWELL_PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DWELL_PRESCALE - 1);

    state_t                  state, state_next;
    cmd_op_t                 op_q;
    logic [N_AXES*POS_W-1:0] target_q;
    logic [ARG_W-1:0]        arg_q;
    logic [ARG_W-1:0]        unit_cnt;
    logic [PRE_W-1:0]        pre_cnt;

    logic signed [POS_W-1:0] pos       [N_AXES];
    logic signed [POS_W:0]   remaining [N_AXES];
    logic signed [POS_W:0]   tgt_ext   [N_AXES];
    logic signed [POS_W:0]   pos_ext   [N_AXES];
    logic signed [POS_W:0]   rel_sum   [N_AXES];
    logic signed [POS_W:0]   load_rem  [N_AXES];
    logic signed [POS_W:0]   chunk     [N_AXES];
    logic [STEP_W-1:0]       chunk_count [N_AXES];
    logic [N_AXES-1:0]       chunk_dir;

    logic rel_ovf, load_zero, after_zero;
    logic handshake, abort_pending, abort_active, dwell_last;
    logic done_next, err_next;

    // Targets and positions are widened by one bit so differences and sums never wrap.
    for (genvar g = 0; g < N_AXES; g++) begin : g_axis
        assign tgt_ext[g]  = $signed({target_q[g*POS_W+POS_W-1], target_q[g*POS_W +: POS_W]});
        assign pos_ext[g]  = $signed({pos[g][POS_W-1], pos[g]});
        assign rel_sum[g]  = pos_ext[g] + tgt_ext[g];
        assign load_rem[g] = (op_q == OP_MOVE_ABS) ? (tgt_ext[g] - pos_ext[g]) : tgt_ext[g];

        scara_chunker #(
            .POS_W    (POS_W),
            .STEP_W   (STEP_W),
            .STEP_MAX (STEP_MAX)
        ) u_chunker (
            .remaining (remaining[g]),
            .count     (chunk_count[g]),
            .dir       (chunk_dir[g]),
            .chunk     (chunk[g])
        );

        assign step_count[g*STEP_W +: STEP_W] = step_valid ? chunk_count[g] : '0;
        assign step_dir[g]                    = step_valid & chunk_dir[g];
        assign pos_current[g*POS_W +: POS_W]  = pos[g];
    end

    always_comb begin
        rel_ovf    = 1'b0;
        load_zero  = 1'b1;
        after_zero = 1'b1;
        for (int i = 0; i < N_AXES; i++) begin
            rel_ovf    = rel_ovf | (rel_sum[i] != $signed({rel_sum[i][POS_W-1], rel_sum[i][POS_W-1:0]}));
            load_zero  = load_zero & (load_rem[i] == '0);
            after_zero = after_zero & (remaining[i] == chunk[i]);
        end
    end

    assign handshake    = step_valid & step_ready;
    assign abort_active = abort | abort_pending;
    assign dwell_last   = (pre_cnt == PRE_LAST) && (unit_cnt == ARG_W'(1));
    assign cmd_ready    = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // An abort seen while a chunk is offered waits for that handshake before leaving ISSUE.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                state_next = ST_IDLE;
                case (op_q)
                    OP_MOVE_ABS, OP_MOVE_REL: begin
                        if (op_q == OP_MOVE_REL && rel_ovf) err_next = 1'b1;
                        else if (load_zero)                 done_next = 1'b1;
                        else                                state_next = ST_ISSUE;
                    end
                    OP_DWELL: begin
                        if (arg_q == '0) done_next = 1'b1;
                        else             state_next = ST_DWELL;
                    end
                    default: done_next = 1'b1;
                endcase
            end
            ST_ISSUE: begin
                if (handshake) begin
                    if (after_zero) begin
                        state_next = ST_IDLE;
                        done_next  = !abort_active;
                    end else if (abort_active) begin
                        state_next = ST_IDLE;
                    end
                end else if (!step_valid && abort_active) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DWELL: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (dwell_last) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q          <= OP_MOVE_ABS;
            target_q      <= '0;
            arg_q         <= '0;
            unit_cnt      <= '0;
            pre_cnt       <= '0;
            step_valid    <= 1'b0;
            abort_pending <= 1'b0;
            pen_state     <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            for (int i = 0; i < N_AXES; i++) begin
                pos[i]       <= HOME_POS;
                remaining[i] <= '0;
            end
        end else begin
            done <= done_next;
            err  <= err_next;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q          <= cmd_op_t'(cmd_op);
                        target_q      <= cmd_target;
                        arg_q         <= cmd_arg;
                        abort_pending <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    for (int i = 0; i < N_AXES; i++) remaining[i] <= load_rem[i];
                    if (op_q == OP_PEN) pen_state <= arg_q[0];
                    unit_cnt   <= arg_q;
                    pre_cnt    <= '0;
                    step_valid <= (state_next == ST_ISSUE);
                end
                ST_ISSUE: begin
                    if (abort) abort_pending <= 1'b1;
                    if (handshake) begin
                        for (int i = 0; i < N_AXES; i++) begin
                            pos[i]       <= pos[i] + chunk[i][POS_W-1:0];
                            remaining[i] <= remaining[i] - chunk[i];
                        end
                        step_valid <= 1'b0;
                    end else begin
                        step_valid <= (state_next == ST_ISSUE);
                    end
                end
                ST_DWELL: begin
                    if (pre_cnt == PRE_LAST) begin
                        pre_cnt  <= '0;
                        unit_cnt <= unit_cnt - ARG_W'(1);
                    end else begin
                        pre_cnt <= pre_cnt + PRE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scara_motion_sequencer.sv
// Randomised self-checking bench for scara_motion_sequencer against a
// position/remaining-distance scoreboard.
module tb_scara_motion_sequencer;

    localparam int POS_W    = 14;
    localparam int STEP_W   = 8;
    localparam int STEP_MAX = 255;
    localparam int PRESCALE = 4;
    localparam int BUDGET   = 3000;
    localparam int POS_MAX  = 8191;
    localparam int POS_MIN  = -8192;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [2*POS_W-1:0]    cmd_target;
    logic [15:0]           cmd_arg;
    logic                  abort;
    logic                  step_valid;
    logic                  step_ready;
    logic [2*STEP_W-1:0]   step_count;
    logic [1:0]            step_dir;
    logic [2*POS_W-1:0]    pos_current;
    logic                  pen_state;
    logic                  busy;
    logic                  done;
    logic                  err;

    int total = 0;
    int bad   = 0;
    int mpos [2];
    int mpen;

    scara_motion_sequencer #(
        .N_AXES         (2),
        .POS_W          (POS_W),
        .STEP_W         (STEP_W),
        .STEP_MAX       (STEP_MAX),
        .HOME_POS       (14'sd0),
        .ARG_W          (16),
        .DWELL_PRESCALE (PRESCALE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_target  (cmd_target),
        .cmd_arg     (cmd_arg),
        .abort       (abort),
        .step_valid  (step_valid),
        .step_ready  (step_ready),
        .step_count  (step_count),
        .step_dir    (step_dir),
        .pos_current (pos_current),
        .pen_state   (pen_state),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int posAxis(input int i);
        logic signed [POS_W-1:0] p;
        p = pos_current[i*POS_W +: POS_W];
        return int'(p);
    endfunction

    function automatic int countAxis(input int i);
        return int'(step_count[i*STEP_W +: STEP_W]);
    endfunction

    function automatic int clampMag(input int r);
        int a;
        a = (r < 0) ? -r : r;
        return (a > STEP_MAX) ? STEP_MAX : a;
    endfunction

    task automatic sendCmd(input int op, input int t0, input int t1, input int arg);
        int w;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        checkOutput("cmd_ready_idle", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_op     = op[1:0];
        cmd_target = {t1[POS_W-1:0], t0[POS_W-1:0]};
        cmd_arg    = arg[15:0];
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("cmd_ready_load", cmd_ready, 0);
    endtask

    // Issue one command, play the stepper driver and score every cycle until the DUT goes idle.
    task automatic applyStimulus(input int op, input int t0, input int t1, input int arg,
                                 input int ready_pct, input int hold, input int abort_at);
        int  tgt [2];
        int  rem [2];
        int  cyc, valid_seen, hs_last, done_cnt, err_cnt, done_cyc, err_cyc, first_valid, busy_cycles;
        bit  exp_err, zero_move, aborting, post_abort, rdy;
        tgt[0] = t0;
        tgt[1] = t1;
        exp_err = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0;
            if (op == 0) rem[i] = tgt[i] - mpos[i];
            if (op == 1) begin
                rem[i] = tgt[i];
                if (mpos[i] + tgt[i] > POS_MAX || mpos[i] + tgt[i] < POS_MIN) exp_err = 1'b1;
            end
        end
        zero_move = (rem[0] == 0) && (rem[1] == 0);
        valid_seen = 0; hs_last = -1; done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
        first_valid = -1; busy_cycles = 0; aborting = 1'b0; post_abort = 1'b0;
        step_ready = 1'b0;
        sendCmd(op, t0, t1, arg);
        cyc = 1;
        while (cyc < BUDGET) begin
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err)  begin err_cnt++;  err_cyc = cyc;  end
            if (busy) busy_cycles++;
            for (int i = 0; i < 2; i++) checkOutput($sformatf("pos%0d", i), posAxis(i), mpos[i]);
            if (post_abort) checkOutput("no_step_after_abort", step_valid, 0);
            if (step_valid) begin
                if (first_valid < 0) first_valid = cyc;
                for (int i = 0; i < 2; i++) begin
                    checkOutput($sformatf("count%0d", i), countAxis(i), clampMag(rem[i]));
                    checkOutput($sformatf("dir%0d", i), step_dir[i], (rem[i] > 0) ? 1 : 0);
                end
                rdy = (valid_seen >= hold) && (int'($urandom_range(99)) < ready_pct);
                if (valid_seen == abort_at) begin
                    abort    = 1'b1;
                    aborting = 1'b1;
                end
                valid_seen++;
            end else begin
                rdy = 1'($urandom_range(1));
            end
            step_ready = rdy;
            if (step_valid && rdy) begin
                for (int i = 0; i < 2; i++) begin
                    int c;
                    c = (rem[i] < 0) ? -clampMag(rem[i]) : clampMag(rem[i]);
                    mpos[i] = mpos[i] + c;
                    rem[i]  = rem[i] - c;
                end
                hs_last = cyc;
                if (aborting) post_abort = 1'b1;
            end
            if (!busy && cyc >= 2) break;
            @(negedge clk);
            abort = 1'b0;
            cyc++;
        end
        abort = 1'b0;
        step_ready = 1'b0;
        if (cyc >= BUDGET) checkOutput("timeout", busy, 0);

        if (op <= 1) begin
            if (exp_err) begin
                checkOutput("err_count", err_cnt, 1);
                checkOutput("err_cycle", err_cyc, 2);
                checkOutput("err_no_done", done_cnt, 0);
                checkOutput("err_no_steps", first_valid, -1);
            end else if (zero_move) begin
                checkOutput("zero_done_cycle", done_cyc, 2);
                checkOutput("zero_no_steps", first_valid, -1);
            end else if (aborting) begin
                checkOutput("abort_no_done", done_cnt, 0);
            end else begin
                checkOutput("first_valid_cycle", first_valid, 2);
                checkOutput("done_after_last_hs", done_cyc, hs_last + 1);
                checkOutput("rem0_cleared", rem[0], 0);
                checkOutput("rem1_cleared", rem[1], 0);
            end
        end else if (op == 2) begin
            checkOutput("dwell_done_cycle", done_cyc, (arg == 0) ? 2 : 2 + arg * PRESCALE);
            if (arg != 0) checkOutput("dwell_busy_cycles", busy_cycles, 1 + arg * PRESCALE);
        end else begin
            mpen = arg & 1;
            checkOutput("pen_done_cycle", done_cyc, 2);
        end
        if (!(op <= 1 && (exp_err || aborting))) checkOutput("done_count", done_cnt, 1);
        if (!(op <= 1 && exp_err)) checkOutput("err_count_zero", err_cnt, 0);
        checkOutput("pen_state", pen_state, mpen);
        @(negedge clk);
        checkOutput("done_one_cycle", done, 0);
        checkOutput("ready_after", cmd_ready, 1);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_target = '0; cmd_arg = '0;
        abort = 1'b0; step_ready = 1'b0;
        mpos[0] = 0; mpos[1] = 0; mpen = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_step_valid", step_valid, 0);
        checkOutput("rst_step_count", step_count, 0);
        checkOutput("rst_step_dir", step_dir, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_pen", pen_state, 0);
        checkOutput("rst_pos0", posAxis(0), 0);
        checkOutput("rst_pos1", posAxis(1), 0);

        applyStimulus(0, 300, -100, 0, 100, 0, -1);
        applyStimulus(1, 10, 20, 0, 100, 5, -1);
        applyStimulus(0, 310, -80, 0, 100, 0, -1);
        applyStimulus(0, 8000, 0, 0, 70, 0, -1);
        applyStimulus(1, 500, 0, 0, 100, 0, -1);
        applyStimulus(2, 0, 0, 3, 100, 0, -1);
        applyStimulus(2, 0, 0, 0, 100, 0, -1);
        applyStimulus(3, 0, 0, 1, 100, 0, -1);
        applyStimulus(0, 0, 0, 0, 100, 0, -1);
        applyStimulus(0, 600, 0, 0, 100, 3, 1);
        checkOutput("abort_pos0", posAxis(0), 255);

        // Abort during a dwell returns to idle on the following cycle.
        sendCmd(2, 0, 0, 5);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("dwell_abort_busy", busy, 0);
        checkOutput("dwell_abort_done", done, 0);
        @(negedge clk);
        checkOutput("dwell_abort_done_late", done, 0);

        for (int n = 0; n < 30; n++) begin
            int kind, pct;
            kind = int'($urandom_range(9));
            pct  = 30 + int'($urandom_range(70));
            if (kind < 4)
                applyStimulus(0, int'($urandom_range(16383)) + POS_MIN, int'($urandom_range(16383)) + POS_MIN, 0, pct, 0, -1);
            else if (kind < 7)
                applyStimulus(1, int'($urandom_range(6000)) - 3000, int'($urandom_range(6000)) - 3000, 0, pct, 0, -1);
            else if (kind == 7)
                applyStimulus(2, 0, 0, int'($urandom_range(3)), pct, 0, -1);
            else
                applyStimulus(3, 0, 0, int'($urandom_range(65535)), pct, 0, -1);
        end

        // Reset in the middle of a move drops everything back to home.
        applyStimulus(3, 0, 0, 1, 100, 0, -1);
        sendCmd(0, 1000, -1000, 0);
        step_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_valid", step_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_step_valid", step_valid, 0);
        checkOutput("midrst_step_count", step_count, 0);
        checkOutput("midrst_step_dir", step_dir, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_pen", pen_state, 0);
        checkOutput("midrst_pos0", posAxis(0), 0);
        checkOutput("midrst_pos1", posAxis(1), 0);
        checkOutput("midrst_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        mpos[0] = 0; mpos[1] = 0; mpen = 0;
        @(negedge clk);
        checkOutput("postrst_done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
